// File: rtl/tick_uart_tx.sv
// UART-style serializer paced by an external one-cycle bit-rate strobe.
// Frame: start bit, DATA_BITS LSB-first, optional parity, STOP_BITS stop bits.
module tick_uart_tx #(
  parameter int DATA_BITS     = 8,
  parameter int TICKS_PER_BIT = 1,
  parameter int PARITY_EN     = 0,
  parameter int PARITY_ODD    = 0,
  parameter int STOP_BITS     = 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 tick_en,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                r_state;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  r_par;
  logic [TW-1:0]         r_tick;
  logic [BW-1:0]         r_bit;
  logic                  w_bit_end;

  assign w_bit_end = tick_en && (r_tick == TW'(TICKS_PER_BIT - 1));

  // tx_out is loaded with the next bit's value on each bit end so the line stays registered.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_tick   <= '0;
      r_bit    <= '0;
      tx_ready <= 1'b1;
      tx_out   <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (r_state != IDLE && tick_en)
        r_tick <= w_bit_end ? '0 : r_tick + TW'(1);
      case (r_state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            r_shift  <= tx_data;
            r_par    <= (^tx_data) ^ (PARITY_ODD != 0);
            r_tick   <= '0;
            r_bit    <= '0;
            r_state  <= START;
            tx_out   <= 1'b0;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b1;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_state <= DATA;
            tx_out  <= r_shift[0];
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_shift <= r_shift >> 1;
            if (r_bit == BW'(DATA_BITS - 1)) begin
              r_bit <= '0;
              if (PARITY_EN != 0) begin
                r_state <= PARITY;
                tx_out  <= r_par;
              end else begin
                r_state <= STOP;
                tx_out  <= 1'b1;
              end
            end else begin
              r_bit  <= r_bit + BW'(1);
              tx_out <= r_shift[1];
            end
          end
        end
        PARITY: begin
          if (w_bit_end) begin
            r_state <= STOP;
            tx_out  <= 1'b1;
          end
        end
        STOP: begin
          // r_bit is reused here to count stop bits
          if (w_bit_end) begin
            if (r_bit == BW'(STOP_BITS - 1)) begin
              r_bit    <= '0;
              r_state  <= IDLE;
              tx_ready <= 1'b1;
              tx_busy  <= 1'b0;
              tx_done  <= 1'b1;
            end else begin
              r_bit <= r_bit + BW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tick_uart_tx.sv
// Bench for tick_uart_tx: four configurations share clock, reset and strobe;
// a per-cycle frame model in the monitor checks line and handshake outputs.
module tb_tick_uart_tx;

  localparam int NL = 4;
  localparam int DB  [NL] = '{8, 8, 8, 7};
  localparam int TPB [NL] = '{1, 2, 2, 3};
  localparam int PE  [NL] = '{0, 1, 1, 0};
  localparam int PO  [NL] = '{0, 0, 1, 0};
  localparam int SB  [NL] = '{1, 1, 1, 2};

  typedef struct {
    logic [15:0] bits;
    int          len;
  } frame_t;

  logic          sys_clk;
  logic          sys_rst_n;
  logic          tick;
  logic [NL-1:0] valid;
  logic [7:0]    data [NL];
  logic [NL-1:0] ready, line, busy, done;

  int checks = 0, failures = 0, cyc = 0;
  int tmo_req = 0, tmo_seen = 0;
  bit rand_ticks = 0;
  int tdiv = 0;

  frame_t     sb_q   [NL][$];
  frame_t     m_fr   [NL];
  bit         m_busy [NL] = '{default: 0};
  int         m_idx  [NL] = '{default: 0};
  int         m_cnt  [NL] = '{default: 0};
  logic [3:0] pred   [NL] = '{default: 4'b1100};

  tick_uart_tx #(.DATA_BITS(8), .TICKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tick_en(tick), .tx_valid(valid[0]), .tx_data(data[0]),
    .tx_ready(ready[0]), .tx_out(line[0]), .tx_busy(busy[0]), .tx_done(done[0]));
  tick_uart_tx #(.DATA_BITS(8), .TICKS_PER_BIT(2), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tick_en(tick), .tx_valid(valid[1]), .tx_data(data[1]),
    .tx_ready(ready[1]), .tx_out(line[1]), .tx_busy(busy[1]), .tx_done(done[1]));
  tick_uart_tx #(.DATA_BITS(8), .TICKS_PER_BIT(2), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tick_en(tick), .tx_valid(valid[2]), .tx_data(data[2]),
    .tx_ready(ready[2]), .tx_out(line[2]), .tx_busy(busy[2]), .tx_done(done[2]));
  tick_uart_tx #(.DATA_BITS(7), .TICKS_PER_BIT(3), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_dut3 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tick_en(tick), .tx_valid(valid[3]), .tx_data(data[3][6:0]),
    .tx_ready(ready[3]), .tx_out(line[3]), .tx_busy(busy[3]), .tx_done(done[3]));

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Strobe source: every 6 cycles, or random density (including back-to-back strobes).
  initial begin
    tick = 1'b0;
    forever begin
      @(posedge sys_clk); #1;
      if (rand_ticks) tick = ($urandom_range(0, 2) == 0);
      else begin
        tdiv = (tdiv == 5) ? 0 : tdiv + 1;
        tick = (tdiv == 0);
      end
    end
  end

  // Expected line bits for one word, from the frame rules.
  function automatic frame_t build(input int l, input logic [7:0] d);
    frame_t f;
    logic   p;
    f.bits    = '1;
    f.bits[0] = 1'b0;
    p = 1'b0;
    for (int i = 0; i < DB[l]; i++) begin
      f.bits[1+i] = d[i];
      p = p ^ d[i];
    end
    f.len = 1 + DB[l] + SB[l];
    if (PE[l] != 0) begin
      f.bits[1+DB[l]] = p ^ (PO[l] != 0);
      f.len = f.len + 1;
    end
    return f;
  endfunction

  // Monitor: compares outputs to the model, then advances the model by one edge.
  always @(negedge sys_clk) begin
    logic [3:0] act, want;
    cyc++;
    if (tmo_req != tmo_seen) begin
      failures++;
      $display("FAIL handshake_timeout cyc=%0d got=%0d expired waits required=0", cyc, tmo_req - tmo_seen);
      tmo_seen = tmo_req;
    end
    for (int l = 0; l < NL; l++) begin
      act  = {line[l], ready[l], busy[l], done[l]};
      want = sys_rst_n ? pred[l] : 4'b1100;
      checks++;
      if (act !== want) begin
        failures++;
        $display("FAIL lane%0d_outputs cyc=%0d {out,ready,busy,done} got=%b required=%b", l, cyc, act, want);
      end
      if (!sys_rst_n) begin
        m_busy[l] = 1'b0;
        pred[l]   = 4'b1100;
      end else if (!m_busy[l]) begin
        pred[l] = 4'b1100;
        if (valid[l]) begin
          checks++;
          if (sb_q[l].size() == 0) begin
            failures++;
            $display("FAIL lane%0d_scoreboard cyc=%0d got=acceptance required=no pending word", l, cyc);
          end else begin
            m_fr[l]   = sb_q[l].pop_front();
            m_busy[l] = 1'b1;
            m_idx[l]  = 0;
            m_cnt[l]  = 0;
            pred[l]   = {m_fr[l].bits[0], 3'b010};
          end
        end
      end else begin
        if (tick) begin
          m_cnt[l]++;
          if (m_cnt[l] == TPB[l]) begin
            m_cnt[l] = 0;
            m_idx[l]++;
          end
        end
        if (m_idx[l] == m_fr[l].len) begin
          m_busy[l] = 1'b0;
          pred[l]   = 4'b1101;
        end else begin
          pred[l] = {m_fr[l].bits[m_idx[l]], 3'b010};
        end
      end
    end
  end

  task automatic cycles(input int n);
    if (n > 0) begin
      repeat (n) @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic send(input int l, input logic [7:0] d);
    int n;
    sb_q[l].push_back(build(l, d));
    data[l]  = d;
    valid[l] = 1'b1;
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (!(ready[l] && sys_rst_n) && n < 2000);
    if (n >= 2000) tmo_req++;
    @(posedge sys_clk); #1;
    valid[l] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (busy != '0 && n < 5000);
    if (n >= 5000) tmo_req++;
    @(posedge sys_clk); #1;
  endtask

  task automatic rst_pulse(input int n);
    sys_rst_n = 1'b0;
    cycles(n);
    sys_rst_n = 1'b1;
  endtask

  task automatic lane_traffic(input int l, input int nw);
    for (int k = 0; k < nw; k++) begin
      cycles($urandom_range(0, 12));
      send(l, 8'($urandom));
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    valid     = '0;
    for (int l = 0; l < NL; l++) data[l] = 8'h00;
    cycles(4);
    sys_rst_n = 1'b1;
    cycles(3);

    send(0, 8'hA5);
    wait_idle();
    cycles(2);

    fork
      begin send(1, 8'hA5); send(1, 8'h01); end
      begin send(2, 8'hA5); send(2, 8'h01); end
      begin send(3, 8'h7F); end
    join
    wait_idle();

    // back-to-back: valid stays high across the done cycle
    send(0, 8'h55);
    send(0, 8'hAA);
    wait_idle();

    // valid pulsed mid-frame must be ignored
    send(0, 8'h3C);
    cycles(15);
    data[0]  = 8'hFF;
    valid[0] = 1'b1;
    cycles(3);
    valid[0] = 1'b0;
    wait_idle();

    // reset mid-frame on two lanes, then stay quiet
    send(0, 8'h96);
    send(3, 8'h2B);
    cycles(20);
    rst_pulse(3);
    cycles(40);

    for (int r = 0; r < 2; r++) begin
      rand_ticks = (r == 1);
      fork
        begin cycles($urandom_range(150, 400)); rst_pulse($urandom_range(1, 4)); end
      join_none
      for (int l = 0; l < NL; l++) begin
        fork
          automatic int ll = l;
          lane_traffic(ll, 6);
        join_none
      end
      wait fork;
      wait_idle();
    end

    cycles(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tick_uart_tx.md
# tick_uart_tx

Serial byte transmitter paced by an external one-cycle bit-rate strobe. It consumes the periodic `clk_flag` pulse from the clock-divider stage on its `tick_en` input. It accepts parallel words over a valid/ready handshake and shifts them out LSB-first on a UART-style line: start bit, data, optional parity, then stop bit(s). All logic runs in the `sys_clk` domain; `tick_en` is a clock enable, never a clock.

## Interface
- `DATA_BITS`, default 8: data bits per frame (5–9).
- `TICKS_PER_BIT`, default 1: `tick_en` strobes per line bit (1–16).
- `PARITY_EN`, default 0: 1 inserts a parity bit after the data.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity; ignored when `PARITY_EN` is 0.
- `STOP_BITS`, default 1: number of stop bits (1 or 2).

Ports:
- `sys_clk`  input  1  system clock; all state changes on its rising edge.
- `sys_rst_n`  input  1  reset; asynchronous, active-low.
- `tick_en`  input  1  one-cycle bit-rate strobe, from the divider's `clk_flag`.
- `tx_valid`  input  1  source has a word on `tx_data`.
- `tx_data`  input  `DATA_BITS`  word to send; sampled only on acceptance.
- `tx_ready`  output  1  block can accept a word this cycle.
- `tx_out`  output  1  serial line; idles high.
- `tx_busy`  output  1  a frame is in progress.
- `tx_done`  output  1  one-cycle pulse when the last stop bit completes.

## Operation
- FSM states: `IDLE`, `START`, `DATA`, `PARITY`, `STOP`. Encoding is free.
- **IDLE:** `tx_ready`=1, `tx_out`=1, `tx_busy`=0. `tick_en` is ignored.
- **Acceptance:** occurs on a rising edge where `tx_valid`=1 and `tx_ready`=1.
  - `tx_data` is latched into the shift register.
  - Parity is computed from the latched word.
  - Tick counter and bit counter clear to 0.
  - State goes to `START`.
- **While busy:** `tx_valid` is ignored and never accepted. The source holds its word until `tx_ready` is high.
- **Bit end:** in any non-IDLE state, each `tick_en`=1 edge increments the tick counter. The edge where the counter is `TICKS_PER_BIT-1` and `tick_en`=1 ends the current bit and resets the counter to 0.
- **START:** line 0. At bit end go to `DATA`.
- **DATA:** line = shift-register LSB. At each bit end, shift right and increment the bit counter. After bit `DATA_BITS-1`, go to `PARITY` if `PARITY_EN`=1, otherwise to `STOP`.
- **PARITY:** line = XOR of the data bits, inverted when `PARITY_ODD`=1. At bit end go to `STOP`.
- **STOP:** line 1 for `STOP_BITS` bit periods. At the final bit end go to `IDLE`.
- **Widths:**
  - Tick counter: `$clog2(TICKS_PER_BIT)` bits, minimum 1.
  - Bit counter: wide enough to hold `DATA_BITS-1`.
  - The tick counter never exceeds `TICKS_PER_BIT-1`; it wraps to 0 at each bit end.

## Timing
- **Reset values:** `tx_out`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0, state `IDLE`, all counters 0.
- **Reset mid-frame:** aborts immediately (asynchronous). `tx_out` returns to 1, no `tx_done` is issued, and the partial frame is lost.
- **Registered outputs:** all outputs come from registers.
- **Start of frame:** `tx_out` falls in the cycle after the acceptance edge. `tx_busy` rises and `tx_ready` falls in the same cycle.
- **Start-bit length:** a `tick_en` pulse on the acceptance edge itself is not counted. The start bit therefore lasts from acceptance until the `TICKS_PER_BIT`-th subsequent strobe. It can be shorter than a full bit period by up to one strobe interval.
- **Other bits:** every later bit lasts exactly `TICKS_PER_BIT` strobe intervals.
- **End of frame:** the edge ending the last stop bit sets, for the following cycle, `tx_done`=1, `tx_ready`=1, `tx_busy`=0.
  - `tx_done` lasts exactly one cycle.
  - A word valid in that cycle is accepted at the next edge, giving back-to-back frames with full-length stop bits.
- **Frame length:** 1 + `DATA_BITS` + `PARITY_EN` + `STOP_BITS` bits.
- **Strobe spacing:** `tick_en` spacing is the source's responsibility. A strobe in consecutive cycles is counted normally.

## Test plan
- **Reset:** assert `sys_rst_n`=0 at arbitrary times, including mid-frame. Required: `tx_out`=1, `tx_ready`=1, `tx_busy`=0 and `tx_done`=0 while in reset; nothing is transmitted after release until a new acceptance.
- **Single byte:** defaults, `tick_en` every 6 cycles, send 0xA5.
  - Line after the start bit: 1,0,1,0,0,1,0,1, then stop 1.
  - Start bit lasts 1–6 cycles; each later bit lasts exactly 6 cycles.
  - One `tx_done` pulse after the stop bit.
- **Parity:** `PARITY_EN`=1, `TICKS_PER_BIT`=2, send 0xA5 then 0x01.
  - Even parity: bits 0 then 1.
  - Repeated with `PARITY_ODD`=1: bits 1 then 0.
- **Back-to-back frames:** hold `tx_valid` high with 0x55 then 0xAA. Required:
  - Second acceptance on the edge right after the `tx_done` cycle.
  - Stop bit of frame 1 is a full 6 cycles.
  - No idle gap beyond that.
- **Valid while busy:** pulse `tx_valid` with 0xFF mid-frame, then drop it. Required: not accepted, current frame unchanged, `tx_ready` stays 0 until the end of the frame.
- **Two stop bits, 7 data bits:** `STOP_BITS`=2, `DATA_BITS`=7, send 0x7F. Required: 10-bit frame with two high stop bits before `tx_done`.
